dsc_reg_shadow: RTL
===================

// Module: dsc_reg_shadow
// PURPOSE
//   Snapshot controller between the CPU debug register file and DebugScreenCore.
//   On each frame boundary (vsync active edge) or on a manual request, it walks
//   src_addr 0..DEPTH-1 and copies src_data into an internal shadow bank.
//   The screen core reads the shadow bank through regAddr/regData, so each
//   displayed frame shows one coherent register set, not values torn mid-scan.
// PARAMETERS
//   DW     32  data width of one register
//   AW     5   address width; DEPTH = 2**AW registers
//   VS_POL 0   active level of vsync (0 = active-low sync pulse)
// PORTS
//   clk       in   1   clock
//   resetn    in   1   asynchronous active-low reset
//   en        in   1   1 = triggers accepted; 0 = all new triggers ignored
//   freeze    in   1   1 = vsync triggers masked; snap_req still honoured
//   vsync     in   1   vsync from screen core
//   snap_req  in   1   manual snapshot request, sampled each cycle
//   src_addr  out  AW  read address to CPU register file
//   src_data  in   DW  CPU register data, combinational for src_addr
//   regAddr   in   AW  display read address from screen core
//   regData   out  DW  shadow[regAddr], combinational
//   busy      out  1   copy in progress
//   snap_done out  1   one-cycle pulse when a full copy completes
//   snap_cnt  out  16  completed-snapshot counter, wraps at 16'hFFFF
// BEHAVIOUR
//   Reset values:
//   - async reset: state=IDLE; src_addr=0; busy=0; snap_done=0; snap_cnt=0; pend=0.
//   - vs_q resets to the inactive level (~VS_POL); every shadow entry = 0, so regData=0.
//   Triggers:
//   - vs_edge = (vsync==VS_POL) && (vs_q!=VS_POL). vs_q registers vsync every cycle.
//   - trig = en && ((vs_edge && !freeze) || snap_req).
//   - A simultaneous vs_edge and snap_req count as one trigger.
//   FSM IDLE:
//   - trig in cycle t -> COPY from t+1, with src_addr=0 and busy=1.
//   FSM COPY:
//   - each cycle, shadow[src_addr] <= src_data; src_addr += 1.
//   - The write for index k occurs at edge t+1+k.
//   - After index DEPTH-1 is written: snap_done=1 for 1 cycle, snap_cnt += 1 (mod 2^16), src_addr=0.
//     - if pend: stay in COPY, busy stays 1, pend cleared.
//     - else: go to IDLE, busy=0.
//   - trig during COPY sets pend. This includes a trig in the last copy cycle.
//   - Any number of triggers during one copy coalesce into one follow-up copy.
//   - en falling during COPY does not abort the copy. A pend already set is still
//     served; no new pend is set while en=0.
//   Other rules:
//   - regData updates as entries are written. A read of index k returns the new
//     value from the cycle after its write.
//   - Reset mid-copy: immediate return to reset values, no snap_done, shadow cleared.
//     After release, the first trigger starts a fresh copy from 0.
//   - snap_cnt wrap: 16'hFFFF + 1 -> 16'h0000, no sticky flag.
// TESTING
//   1 reset: resetn=0, regAddr sweep 0..31 -> regData=0, busy=0, snap_cnt=0,
//     src_addr=0.
//   2 frame copy: mem[i]=$random, vsync 1->0 -> busy for exactly 32 cycles,
//     src_addr 0..31 in order, snap_done one pulse, snap_cnt=1, regData==mem[a] for all a.
//   3 freeze: freeze=1, vsync edge -> busy stays 0, shadow unchanged;
//     then snap_req 1 cycle -> full copy, snap_cnt=2.
//   4 coalesce: snap_req at index 10 and again at index 20 of a copy ->
//     exactly one follow-up copy, busy high for 64 contiguous cycles,
//     two snap_done pulses, snap_cnt+=2.
//   5 reset mid-copy: resetn=0 at index 15 -> busy=0 and regData=0 immediately,
//     no snap_done; next vsync edge -> complete copy from index 0.
//   6 enable: en=0, vsync edges plus snap_req -> no copy, snap_cnt unchanged;
//     en=1 -> next vsync edge copies.

Source files
------------

// File: rtl/dsc_reg_shadow_if.sv
// Bus between the snapshot controller, the CPU debug register file and the screen core.
interface dsc_reg_shadow_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          en;
  logic          freeze;
  logic          vsync;
  logic          snap_req;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data;
  logic [AW-1:0] regAddr;
  logic [DW-1:0] regData;
  logic          busy;
  logic          snap_done;
  logic [15:0]   snap_cnt;

  modport master (
    output en, freeze, vsync, snap_req, src_data, regAddr,
    input  src_addr, regData, busy, snap_done, snap_cnt
  );

  modport slave (
    input  en, freeze, vsync, snap_req, src_data, regAddr,
    output src_addr, regData, busy, snap_done, snap_cnt
  );
endinterface

// File: rtl/dsc_reg_shadow.sv
// Snapshot controller: copies the CPU debug register file into a shadow bank on
// each vsync edge or manual request, so the screen core sees one coherent set per frame.
module dsc_reg_shadow #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter bit          VS_POL = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  dsc_reg_shadow_if.slave  bus
);

  localparam int unsigned   DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t        state;
  logic          pend;
  logic          vs_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] src_addr_q;
  logic [15:0]   cnt_q;
  logic [DW-1:0] shadow [DEPTH];

  logic vs_edge_c;
  logic trig_c;

  // A simultaneous vsync edge and manual request collapse into a single trigger.
  assign vs_edge_c = (bus.vsync == VS_POL) && (vs_q != VS_POL);
  assign trig_c    = bus.en && ((vs_edge_c && !bus.freeze) || bus.snap_req);

  assign bus.src_addr  = src_addr_q;
  assign bus.busy      = busy_q;
  assign bus.snap_done = done_q;
  assign bus.snap_cnt  = cnt_q;
  assign bus.regData   = shadow[bus.regAddr];

  // Copy sequencer; triggers arriving mid-copy coalesce into one follow-up pass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      pend       <= 1'b0;
      vs_q       <= ~VS_POL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_addr_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        shadow[i] <= '0;
      end
    end else begin
      vs_q   <= bus.vsync;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_c) begin
            state      <= COPY;
            src_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        COPY: begin
          shadow[src_addr_q] <= bus.src_data;
          if (src_addr_q == LAST) begin
            done_q     <= 1'b1;
            cnt_q      <= cnt_q + 16'd1;
            src_addr_q <= '0;
            // A trigger on the final cycle is served exactly like an earlier one.
            if (pend || trig_c) begin
              pend <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            src_addr_q <= src_addr_q + AW'(1);
            if (trig_c) begin
              pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
